shared_adder_sched: RTL

Round-robin scheduler that time-shares one `WIDTH`-bit adder among `NREQ` requesters. It supports two operation types. A single add returns `a+b`. A chained add returns `(a+b)+b`, with the second pass reusing the same adder. The block replaces per-requester adders in the arithmetic datapath and trades latency for area, in the same way as the shared-adder/mux resource-sharing structure.

---
 rtl/shared_adder_pkg.sv | 21 ++
 rtl/shared_adder_sched_rr_arbiter.sv | 35 +++
 rtl/shared_adder_sched.sv | 132 +++++++++++++
 3 files changed

// File: rtl/shared_adder_pkg.sv
// Shared definitions for the shared_adder_sched block.
//   state_t : FSM state encoding for the adder scheduler
//   OP_ADD  : op code for a single add, result = a + b
//   OP_ADD2 : op code for a chained add, result = (a + b) + b
package shared_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic OP_ADD  = 1'b0;
  localparam logic OP_ADD2 = 1'b1;

  // Number of guard bits on the accumulator. Three operand-sized terms are
  // summed at most, and 3*(2^W-1) always fits in W+2 bits.
  localparam int ACC_GUARD = 2;

endpackage

// File: rtl/shared_adder_sched_rr_arbiter.sv
// Round-robin arbiter, purely combinational.
//   req        : request level per requester
//   last_grant : ID granted most recently; it gets the lowest priority
//   gnt_id     : winning requester ID (0 when nothing is requested)
//   gnt_valid  : at least one request is present
// The search starts at last_grant+1 and ascends with wrap-around.
module rr_arbiter #(
  parameter  int IDW  = 2,
  localparam int NREQ = 1 << IDW
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_valid
);

  logic [IDW-1:0] idx;

  // Walk the offsets from farthest to nearest so that the nearest requester
  // after last_grant is written last and therefore wins. Offset NREQ wraps to
  // last_grant itself, which is the lowest-priority slot.
  always_comb begin
    gnt_id    = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = last_grant + IDW'(k);
      if (req[idx]) begin
        gnt_id    = idx;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_adder_sched.sv
// shared_adder_sched: time-shares one adder among NREQ requesters.
//   clk, rst  : clock, synchronous active-high reset
//   req       : per-requester request level
//   op        : per-requester op (OP_ADD: a+b, OP_ADD2: (a+b)+b)
//   a_bus     : packed operand A, requester i at [i*WIDTH +: WIDTH]
//   b_bus     : packed operand B, same packing
//   ack       : one-hot, one-cycle completion pulse
//   res_valid : one-cycle result strobe, coincident with ack
//   res_id    : ID of the completed requester
//   result    : zero-extended sum, holds until the next completion
//   busy      : high whenever the FSM is not in IDLE
//
// Handshake: a requester raises req and holds it (with stable intent) until
// it sees its ack bit. Operands and op are captured only on the grant edge,
// so they may change freely afterwards. A req still high during the ack cycle
// is a fresh request; round-robin then ranks that requester last.
//
// Timing: grant on edge E0, PASS1 during the next cycle, optional PASS2,
// then DONE; ack/res_valid/result are visible in the cycle after DONE, which
// is itself an IDLE cycle and may grant again on the edge ending it.
module shared_adder_sched
  import shared_adder_pkg::*;
#(
  parameter  int WIDTH = 3,
  parameter  int IDW   = 2,
  localparam int NREQ  = 1 << IDW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       op,
  input  logic [NREQ*WIDTH-1:0] a_bus,
  input  logic [NREQ*WIDTH-1:0] b_bus,
  output logic [NREQ-1:0]       ack,
  output logic                  res_valid,
  output logic [IDW-1:0]        res_id,
  output logic [WIDTH+1:0]      result,
  output logic                  busy
);

  localparam int AW = WIDTH + ACC_GUARD;

  state_t          state;
  logic [IDW-1:0]  g_r;
  logic [IDW-1:0]  last_grant;
  logic [AW-1:0]   a_r;
  logic [AW-1:0]   b_r;
  logic [AW-1:0]   acc;
  logic            op_r;

  logic [IDW-1:0]  gnt_id;
  logic            gnt_valid;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic            op_sel;

  logic [AW-1:0]   add_lhs;
  logic [AW-1:0]   sum;
  logic [NREQ-1:0] g_onehot;

  rr_arbiter #(.IDW(IDW)) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .gnt_id     (gnt_id),
    .gnt_valid  (gnt_valid)
  );

  // Operand selection for the current arbitration winner.
  assign a_sel  = a_bus[int'(gnt_id)*WIDTH +: WIDTH];
  assign b_sel  = b_bus[int'(gnt_id)*WIDTH +: WIDTH];
  assign op_sel = op[gnt_id];

  // The one shared adder: first pass adds a, second pass re-adds b onto acc.
  assign add_lhs = (state == PASS2) ? acc : a_r;
  assign sum     = add_lhs + b_r;

  always_comb begin
    g_onehot      = '0;
    g_onehot[g_r] = 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      g_r        <= '0;
      last_grant <= IDW'(NREQ - 1);
      a_r        <= '0;
      b_r        <= '0;
      acc        <= '0;
      op_r       <= OP_ADD;
      ack        <= '0;
      res_valid  <= 1'b0;
      res_id     <= '0;
      result     <= '0;
    end else begin
      // Completion strobes are single-cycle unless DONE re-asserts them.
      ack       <= '0;
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            g_r   <= gnt_id;
            a_r   <= AW'(a_sel);
            b_r   <= AW'(b_sel);
            op_r  <= op_sel;
            state <= PASS1;
          end
        end
        PASS1: begin
          acc   <= sum;
          state <= (op_r == OP_ADD2) ? PASS2 : DONE;
        end
        PASS2: begin
          acc   <= sum;
          state <= DONE;
        end
        DONE: begin
          result     <= acc;
          res_id     <= g_r;
          res_valid  <= 1'b1;
          ack        <= g_onehot;
          last_grant <= g_r;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
